// File: rtl/assist_pwm_driver.sv
// rtl/assist_pwm_driver.sv - soft-start, brake/fault-gated fixed-period PWM gate driver
//
// Takes the signed 13-bit assistance demand and turns it into a 12-bit target.
// The target is slew-limited only while rising, so braking or dropping demand
// takes effect at once. The limited level sets a PWM duty, which is latched once
// per period so every period has a constant duty. A latched over-current fault
// holds the drive off until it is explicitly cleared.
module assist_pwm_driver #(
   parameter int PWM_BITS   = 10,
   parameter int SLEW_STEP  = 8,
   parameter int UPDATE_DIV = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [12:0]         assist_req,
   input  logic                enable,
   input  logic                brake,
   input  logic                fault_in,
   input  logic                clear_fault,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] duty,
   output logic [1:0]          state,
   output logic                fault_latched
);

   localparam int                  DIV_W    = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(UPDATE_DIV - 1);
   localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
   localparam logic [12:0]         STEP13   = 13'(SLEW_STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RAMP  = 2'b01,
      S_RUN   = 2'b10,
      S_FAULT = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [11:0]         level_q, level_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                pwm_q, pwm_d;

   logic [11:0]         target;
   logic                tick;
   logic                kill;
   logic [12:0]         level_sum;

   // Target demand: negative demand, disarm or brake all request zero drive
   always_comb begin
      target = 12'd0;
      if (!(assist_req[12] || !enable || brake)) begin
         target = assist_req[11:0];
      end
   end

   assign tick      = (div_q == DIV_LAST);
   assign kill      = fault_in || (state_q == S_FAULT);
   // 13-bit sum so a step near full scale cannot wrap past the target
   assign level_sum = {1'b0, level_q} + STEP13;

   // Free-running slew divider and PWM period counter
   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      cnt_d = cnt_q + PWM_BITS'(1);
   end

   // Level: drop instantly, rise by at most one step per slew tick
   always_comb begin
      level_d = level_q;
      if (kill) begin
         level_d = 12'd0;
      end else if (target < level_q) begin
         level_d = target;
      end else if ((target > level_q) && tick) begin
         if (level_sum > {1'b0, target}) begin
            level_d = target;
         end else begin
            level_d = level_sum[11:0];
         end
      end
   end

   // Duty: only changes at the period wrap, except a fault clears it at once
   always_comb begin
      duty_d = duty_q;
      if (kill) begin
         duty_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         duty_d = level_q[11 -: PWM_BITS];
      end
   end

   // Gate drive: compare plus direct brake/fault gating so they act on the next edge
   always_comb begin
      pwm_d = (cnt_q < duty_q) && !brake && !fault_in && (state_q != S_FAULT);
   end

   // Mode FSM: fault_in dominates, then fault hold, then brake, then demand tracking
   always_comb begin
      state_d = state_q;
      if (fault_in) begin
         state_d = S_FAULT;
      end else if (state_q == S_FAULT) begin
         if (clear_fault) begin
            state_d = S_IDLE;
         end
      end else if (brake) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (target != 12'd0) begin
                  state_d = S_RAMP;
               end
            end
            S_RAMP: begin
               if (target == 12'd0) begin
                  state_d = S_IDLE;
               end else if (level_d == target) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (target == 12'd0) begin
                  state_d = S_IDLE;
               end else if (target > level_q) begin
                  state_d = S_RAMP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers with synchronous reset overriding every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= 12'd0;
         div_q   <= '0;
         cnt_q   <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
      end
   end

   assign pwm_out       = pwm_q;
   assign duty          = duty_q;
   assign state         = state_q;
   assign fault_latched = (state_q == S_FAULT);

endmodule
